// File: rtl/booth_seq_multiplier_param.sv
// rtl/booth_seq_multiplier_param.sv - parametrised radix-2 Booth sequential multiplier
//
// Purpose: multiplies two WIDTH-bit operands, signed or unsigned per operation,
// one Booth step per clock. Fixed latency; product is held until the next completion.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        request a multiply (sampled only while idle)
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   M            multiplicand (sampled with start)
//   Q            multiplier (sampled with start)
//   busy         high while an operation is in progress
//   done         one-cycle pulse when P is newly valid
//   P            2*WIDTH-bit product register

module booth_seq_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  // One guard bit lets unsigned operands run through the same signed Booth datapath.
  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [N-1:0]         a_q, a_d;
  logic [N-1:0]         qr_q, qr_d;
  logic [N-1:0]         mr_q, mr_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [N-1:0]         sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qr_d    = qr_q;
    mr_d    = mr_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
    sum     = a_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mr_d    = {signed_mode & M[WIDTH-1], M};
          qr_d    = {signed_mode & Q[WIDTH-1], Q};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      default: begin
        case ({qr_q[0], qm1_q})
          2'b01:   sum = a_q + mr_q;
          2'b10:   sum = a_q - mr_q;
          default: sum = a_q;
        endcase

        // Arithmetic right shift of {sum, qr, qm1} by one bit.
        a_d   = {sum[N-1], sum[N-1:1]};
        qr_d  = {sum[0], qr_q[N-1:1]};
        qm1_d = qr_q[0];
        cnt_d = cnt_q - CW'(1);

        if (cnt_q == CW'(1)) begin
          // Top two bits of the 2N-bit result are sign copies; drop them.
          p_d     = {a_d[N-3:0], qr_d};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      mr_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      mr_q    <= mr_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_booth_seq_multiplier_param.sv
// tb/tb_booth_seq_multiplier_param.sv - self-checking bench for booth_seq_multiplier_param

module tb_booth_seq_multiplier_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, sm8;
  logic [7:0]  m8, q8;
  logic        busy8, done8;
  logic [15:0] p8;
  logic        start4, sm4;
  logic [3:0]  m4, q4;
  logic        busy4, done4;
  logic [7:0]  p4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .M(m8), .Q(q8), .busy(busy8), .done(done8), .P(p8)
  );

  booth_seq_multiplier_param #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
    .M(m4), .Q(q4), .busy(busy4), .done(done4), .P(p4)
  );

  typedef struct {
    bit          s;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input bit s,
                                          input logic [31:0] m, input logic [31:0] q);
    longint a, b, pr;
    a = longint'(m);
    b = longint'(q);
    if (s && m[w-1]) a = a - (longint'(1) << w);
    if (s && q[w-1]) b = b - (longint'(1) << w);
    pr = a * b;
    return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Issues one operation and waits for done. edges counts clock edges from the
  // accepting edge (inclusive) to the edge that raises done; -1 on timeout.
  task automatic run_op(input bit w4, input bit s, input logic [7:0] m, input logic [7:0] q,
                        output logic [15:0] p, output int edges,
                        output bit busy_ok, output bit pulse_ok);
    edges    = -1;
    p        = 16'hxxxx;
    busy_ok  = 1'b0;
    pulse_ok = 1'b0;
    @(negedge clk);
    if (w4) begin start4 = 1'b1; sm4 = s; m4 = m[3:0]; q4 = q[3:0]; end
    else    begin start8 = 1'b1; sm8 = s; m8 = m;      q8 = q;      end
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    busy_ok = w4 ? busy4 : busy8;
    for (int k = 1; k <= 40; k++) begin
      if (w4 ? done4 : done8) begin
        edges = k;
        p = w4 ? {8'h00, p4} : p8;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (edges > 0) begin
      @(posedge clk);
      @(negedge clk);
      pulse_ok = !(w4 ? done4 : done8) && !(w4 ? busy4 : busy8);
    end
  endtask

  vec_t        vecs[$];
  logic [15:0] p;
  int          edges;
  bit          busy_ok, pulse_ok;
  int          n_done;
  logic [15:0] p_seen;
  int          t_done[$];
  logic [15:0] p_done[$];
  logic [7:0]  rm, rq;
  bit          rs;

  initial begin
    vecs.push_back('{1'b1, 8'h80, 8'h80, 16'h4000});
    vecs.push_back('{1'b1, 8'hFF, 8'h7F, 16'hFF81});
    vecs.push_back('{1'b0, 8'hFF, 8'hFF, 16'hFE01});
    vecs.push_back('{1'b0, 8'h00, 8'hA5, 16'h0000});
    vecs.push_back('{1'b1, 8'h7F, 8'h7F, 16'h3F01});
    vecs.push_back('{1'b1, 8'h80, 8'h7F, 16'hC080});
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 16'h0001});
    vecs.push_back('{1'b0, 8'h80, 8'h02, 16'h0100});

    reset = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
    start4 = 1'b0; sm4 = 1'b0; m4 = '0; q4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy8", 64'(busy8), 64'd0);
    check("reset_done8", 64'(done8), 64'd0);
    check("reset_p8",    64'(p8),    64'd0);
    check("reset_busy4", 64'(busy4), 64'd0);
    check("reset_done4", 64'(done4), 64'd0);
    check("reset_p4",    64'(p4),    64'd0);

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].s, vecs[i].m, vecs[i].q, p, edges, busy_ok, pulse_ok);
      check($sformatf("vec%0d_p", i), 64'(p), 64'(vecs[i].p));
      check($sformatf("vec%0d_latency", i), 64'(edges), 64'd10);
      check($sformatf("vec%0d_busy", i), 64'(busy_ok), 64'd1);
      check($sformatf("vec%0d_single_pulse", i), 64'(pulse_ok), 64'd1);
    end

    for (int i = 0; i < 60; i++) begin
      rs = 1'(i & 1);
      rm = 8'($urandom);
      rq = 8'($urandom);
      run_op(1'b0, rs, rm, rq, p, edges, busy_ok, pulse_ok);
      check($sformatf("rand8 s=%0d %0h*%0h", rs, rm, rq), 64'(p), ref_mul(8, rs, 32'(rm), 32'(rq)));
    end

    // Ignore-while-busy: a second start mid-operation must be dropped.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; m8 = 8'd3; q8 = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n_done = 0;
    p_seen = '0;
    for (int c = 1; c <= 30; c++) begin
      if (done8) begin n_done++; p_seen = p8; end
      if (c == 4) begin start8 = 1'b1; m8 = 8'd7; q8 = 8'd7; end
      if (c == 5) start8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    check("ignore_busy_p", 64'(p_seen), 64'h000F);
    check("ignore_busy_done_count", 64'(n_done), 64'd1);
    check("ignore_busy_idle", 64'(busy8), 64'd0);

    // Back-to-back with start held high, new operands presented at each done.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; m8 = 8'd6; q8 = 8'd7;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        t_done.push_back(c);
        p_done.push_back(p8);
        if (t_done.size() == 1) begin m8 = 8'hFE; q8 = 8'd3; end
        else begin start8 = 1'b0; break; end
      end
    end
    start8 = 1'b0;
    check("b2b_done_count", 64'(t_done.size()), 64'd2);
    if (t_done.size() == 2) begin
      check("b2b_p1", 64'(p_done[0]), 64'h002A);
      check("b2b_p2", 64'(p_done[1]), 64'hFFFA);
      check("b2b_spacing", 64'(t_done[1] - t_done[0]), 64'd10);
    end

    // Reset mid-operation: P was 0xFFFA, must be cleared, no done pulse.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; m8 = 8'd9; q8 = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 4; c++) begin
      if (done8) n_done++;
      if (c == 4) reset = 1'b1;
      else begin @(posedge clk); @(negedge clk); end
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", 64'(busy8), 64'd0);
    check("midreset_done", 64'(done8), 64'd0);
    check("midreset_p",    64'(p8),    64'd0);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) n_done++;
    end
    check("midreset_no_done", 64'(n_done), 64'd0);
    run_op(1'b0, 1'b1, 8'hFD, 8'h05, p, edges, busy_ok, pulse_ok);
    check("after_reset_p", 64'(p), 64'hFFF1);
    check("after_reset_latency", 64'(edges), 64'd10);

    // WIDTH=4 directed case then exhaustive sweep in both modes.
    run_op(1'b1, 1'b1, 8'h07, 8'h08, p, edges, busy_ok, pulse_ok);
    check("w4_7x8_p", 64'(p), 64'h00C8);
    check("w4_latency", 64'(edges), 64'd6);
    check("w4_single_pulse", 64'(pulse_ok), 64'd1);
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 16; m++) begin
        for (int q = 0; q < 16; q++) begin
          run_op(1'b1, 1'(s), 8'(m), 8'(q), p, edges, busy_ok, pulse_ok);
          check($sformatf("w4 s=%0d %0h*%0h", s, m, q), 64'(p), ref_mul(4, 1'(s), 32'(m), 32'(q)));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_seq_multiplier_param.md
# booth_seq_multiplier_param

Parametrised radix-2 Booth sequential multiplier with a start/busy/done handshake and a per-operation signed/unsigned mode select. It computes one Booth step per clock, has a fixed latency, and holds its product until the next operation completes. It is the general-width successor to the 4-bit sequential Booth multiplier in the arithmetic datapath library, and it is intended for control-path multiplies where area matters more than throughput.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when idle.
- signed_mode  input  1  1 = operands are two's complement, 0 = operands are unsigned; sampled with start.
- M  input  WIDTH  multiplicand; sampled with start.
- Q  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse marking the cycle in which P is newly valid.
- P  output  2*WIDTH  product register; holds its value between completions.

## Operation
- Internal operand width is N = WIDTH+1. Signed mode sign-extends M and Q by one bit; unsigned mode zero-extends them. Both modes therefore run signed Booth on N bits.
- Working registers:
  - A, N bits, accumulator.
  - Qr, N bits, multiplier.
  - Mr, N bits, multiplicand.
  - q_m1, 1 bit, Booth history bit.
  - cnt, wide enough to hold N.
- State machine: IDLE and RUN.
- IDLE with start=1:
  - Mr and Qr take the extended operands; A=0; q_m1=0; cnt=N.
  - busy goes to 1; next state is RUN.
- IDLE with start=0: hold all registers.
- RUN, one step per cycle, based on {Qr[0], q_m1}:
  - 01: A+Mr.
  - 10: A-Mr.
  - 00 or 11: A unchanged.
  - All A arithmetic is mod 2^N.
  - Then arithmetic-right-shift {A', Qr, q_m1} by one as a 2N+1-bit value. The old Qr[0] becomes q_m1 and A'[0] enters Qr[N-1].
  - cnt decrements by 1.
- Completion, on the RUN step where cnt==1:
  - P takes the low 2*WIDTH bits of the post-shift {A, Qr}.
  - done=1, busy=0, next state IDLE.
- Result rules:
  - Signed mode: P is the exact two's-complement product.
  - Unsigned mode: P is the exact unsigned product.
  - No overflow is possible because 2*WIDTH bits always hold the full result.
- start, M, Q and signed_mode are ignored while busy=1. There is no queueing.
- Back-to-back: start=1 in the cycle where done=1 (state is IDLE) is accepted.
- No abort input exists. reset is the only way to cancel an operation.

## Timing
- Reset values: busy=0, done=0, P=0, state IDLE, and all working registers 0. reset takes priority over start in the same cycle.
- Reset mid-operation: the operation is discarded and the cycle after reset shows reset values. No done pulse is produced, and P is cleared to 0 rather than holding its old value.
- Accept: start is sampled at edge E0. busy is high from after E0 until after edge E0+N.
- Latency: the N RUN steps occur at edges E0+1 .. E0+N. P and done update at E0+N.
  - done is high for exactly the one cycle following E0+N.
  - Start-to-done is N+1 = WIDTH+2 edges (10 for WIDTH=8).
- Throughput: one operation per WIDTH+2 cycles when start is held high continuously.
- P changes only at a completion edge or on reset.

## Test plan
- WIDTH=8, signed_mode=1:
  - M=0x80, Q=0x80 -> P=0x4000.
  - M=0xFF, Q=0x7F -> P=0xFF81.
  - done pulses once, exactly 10 edges after start is accepted.
- WIDTH=8, signed_mode=0:
  - M=0xFF, Q=0xFF -> P=0xFE01.
  - M=0x00, Q=0xA5 -> P=0x0000.
- Ignore-while-busy: start M=3, Q=5. Pulse start with M=7, Q=7 on cycle 4 -> P=0x000F, and only one done pulse.
- Back-to-back: hold start=1 and change the operands at each done -> results 6*7=0x002A then (signed) -2*3=0xFFFA, with done pulses 10 cycles apart.
- Reset mid-op: assert reset 5 cycles after start -> next cycle busy=0, done=0, P=0. A following start gives the correct result.
- WIDTH=4, signed_mode=1: M=0x7, Q=0x8 -> P=0xC8, done 6 edges after start. Run exhaustive random compare over all 2^8 operand pairs in both modes.
